// File: rtl/soc_evt_cdc_src.sv
// Source half of the SoC-to-cluster event-bus crossing: write side of an async
// register FIFO that publishes a Gray write pointer and the storage array.
module soc_evt_cdc_src #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_W      = $clog2(DEPTH) + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        evt_valid_i,
    input  logic [DATA_WIDTH-1:0]       evt_data_i,
    output logic                        evt_ready_o,
    output logic [PTR_W-1:0]            wptr_gray_o,
    output logic [DEPTH*DATA_WIDTH-1:0] buf_data_o,
    input  logic [PTR_W-1:0]            rptr_gray_i,
    output logic [PTR_W-1:0]            level_o,
    output logic                        overflow_o
);

    localparam int AW = PTR_W - 1;
    // Inverting the two MSBs of a Gray pointer maps it to the pointer DEPTH ahead.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(2'b11) << (PTR_W - 2);

    function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
        logic [PTR_W-1:0] b;
        b[PTR_W-1] = g[PTR_W-1];
        for (int i = PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PTR_W-1:0]      wbin_r;
    logic [PTR_W-1:0]      wgray_r;
    logic [PTR_W-1:0]      rsync1_r;
    logic [PTR_W-1:0]      rsync2_r;
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [7:0]            stall_cnt_r;
    logic                  overflow_r;
    logic [PTR_W-1:0]      level_r;
    logic [PTR_W-1:0]      wbin_nxt_s;
    logic                  full_s;
    logic                  wr_s;
    logic                  stall_s;

    assign full_s     = (wgray_r == (rsync2_r ^ FULL_MASK));
    assign wr_s       = evt_valid_i && !full_s;
    assign stall_s    = evt_valid_i && full_s;
    assign wbin_nxt_s = wbin_r + PTR_W'(1);

    // Write pointer in binary and Gray, both advanced on an accepted word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wbin_r  <= '0;
            wgray_r <= '0;
        end else if (wr_s) begin
            wbin_r  <= wbin_nxt_s;
            wgray_r <= wbin_nxt_s ^ (wbin_nxt_s >> 1);
        end
    end

    // Two-flop synchronizer for the sink's Gray read pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsync1_r <= '0;
            rsync2_r <= '0;
        end else begin
            rsync1_r <= rptr_gray_i;
            rsync2_r <= rsync1_r;
        end
    end

    // Storage array; full blocks writes so unread entries are never overwritten.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_r[k] <= '0;
            end
        end else if (wr_s) begin
            mem_r[wbin_r[AW-1:0]] <= evt_data_i;
        end
    end

    // Fill level relative to the synchronized read pointer, modulo 2^PTR_W.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_r <= '0;
        end else begin
            level_r <= wbin_r - gray2bin(rsync2_r);
        end
    end

    // Consecutive-stall counter and sticky overflow once a stall outlasts 255 cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_r <= 8'd0;
            overflow_r  <= 1'b0;
        end else begin
            if (stall_s) begin
                if (stall_cnt_r != 8'hFF) begin
                    stall_cnt_r <= stall_cnt_r + 8'd1;
                end else begin
                    overflow_r <= 1'b1;
                end
            end else begin
                stall_cnt_r <= 8'd0;
            end
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < DEPTH; gk++) begin : g_buf
            assign buf_data_o[gk*DATA_WIDTH +: DATA_WIDTH] = mem_r[gk];
        end
    endgenerate

    assign evt_ready_o = !full_s;
    assign wptr_gray_o = wgray_r;
    assign level_o     = level_r;
    assign overflow_o  = overflow_r;

endmodule

// File: tb/tb_soc_evt_cdc_src.sv
// Directed-plus-random bench for soc_evt_cdc_src against a count-based FIFO model.
module tb_soc_evt_cdc_src;
    localparam int DW = 8;
    localparam int D  = 8;
    localparam int PW = 4;

    logic            clk = 1'b0;
    logic            rst_ni = 1'b1;
    logic            evt_valid_i = 1'b0;
    logic [DW-1:0]   evt_data_i = '0;
    logic            evt_ready_o;
    logic [PW-1:0]   wptr_gray_o;
    logic [D*DW-1:0] buf_data_o;
    logic [PW-1:0]   rptr_gray_i = '0;
    logic [PW-1:0]   level_o;
    logic            overflow_o;

    soc_evt_cdc_src #(.DATA_WIDTH(DW), .DEPTH(D)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .evt_valid_i(evt_valid_i), .evt_data_i(evt_data_i),
        .evt_ready_o(evt_ready_o), .wptr_gray_o(wptr_gray_o), .buf_data_o(buf_data_o),
        .rptr_gray_i(rptr_gray_i), .level_o(level_o), .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    // Model: total words written, read count as seen after the 2-edge sync delay.
    int m_wr, m_rs1, m_rs2, rd_cnt, run, m_level;
    bit m_ovf, seen_wrap;
    logic [DW-1:0] m_mem [D];
    logic [DW-1:0] exp_q [$];
    logic [PW-1:0] prev_w;
    int hist [$];

    function automatic logic [PW-1:0] to_gray(input int v);
        logic [PW-1:0] b;
        b = v[PW-1:0];
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = 0; m_rs1 = 0; m_rs2 = 0; rd_cnt = 0; run = 0; m_level = 0; m_ovf = 0;
        for (int k = 0; k < D; k++) m_mem[k] = '0;
        exp_q.delete();
        prev_w = '0;
    endtask

    task automatic check_all(input bit acc);
        logic [D*DW-1:0] pk;
        for (int k = 0; k < D; k++) pk[k*DW +: DW] = m_mem[k];
        chk("ready", evt_ready_o, ((m_wr - m_rs2) < D) ? 1 : 0);
        chk("wptr", wptr_gray_o, to_gray(m_wr));
        chk("level", level_o, m_level);
        chk("buf", buf_data_o, pk);
        chk("overflow", overflow_o, m_ovf);
        chk("gray_step", $countones(wptr_gray_o ^ prev_w), acc ? 1 : 0);
        if (acc && prev_w == 4'b1000 && wptr_gray_o == 4'b0000) seen_wrap = 1;
        prev_w = wptr_gray_o;
    endtask

    task automatic step();
        bit rdy, acc;
        rptr_gray_i = to_gray(rd_cnt);
        @(posedge clk);
        rdy = (m_wr - m_rs2) < D;
        acc = evt_valid_i && rdy;
        m_level = m_wr - m_rs2;
        if (acc) begin
            m_mem[m_wr % D] = evt_data_i;
            exp_q.push_back(evt_data_i);
            m_wr++;
        end
        run = (evt_valid_i && !rdy) ? run + 1 : 0;
        if (run >= 256) m_ovf = 1;
        m_rs2 = m_rs1;
        m_rs1 = rd_cnt;
        #1;
        check_all(acc);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready", evt_ready_o, 1);
        chk("rst_wptr", wptr_gray_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_buf", buf_data_o, 0);
        chk("rst_ovf", overflow_o, 0);
    endtask

    initial begin
        seen_wrap = 0;
        model_reset();
        #1 rst_ni = 1'b0;
        #11;
        check_reset_outputs();
        rst_ni = 1'b1;

        // Fill with 0x11..0x88 while the reader stays at 0.
        for (int i = 0; i < 8; i++) begin
            evt_valid_i = 1'b1;
            evt_data_i = 8'((i + 1) * 8'h11);
            step();
        end
        chk("fill_ready", evt_ready_o, 0);
        chk("fill_buf", buf_data_o, 64'h8877665544332211);
        evt_data_i = 8'h99;
        step();
        chk("fill_blocked_wptr", wptr_gray_o, 4'b1100);
        chk("fill_level", level_o, 8);

        // Drain one entry: ready after 2 edges, level one edge later.
        evt_valid_i = 1'b0;
        rd_cnt = 1;
        step();
        chk("drain_ready_e1", evt_ready_o, 0);
        step();
        chk("drain_ready_e2", evt_ready_o, 1);
        step();
        chk("drain_level", level_o, 7);

        // Overflow: 254 stalls stay clear, 256 stalls set the sticky flag.
        evt_valid_i = 1'b1;
        evt_data_i = 8'($urandom);
        step();
        repeat (254) step();
        chk("ovf_254", overflow_o, 0);
        evt_valid_i = 1'b0;
        step();
        evt_valid_i = 1'b1;
        repeat (255) step();
        chk("ovf_255", overflow_o, 0);
        step();
        chk("ovf_256", overflow_o, 1);
        evt_valid_i = 1'b0;
        rd_cnt = m_wr;
        repeat (4) step();
        chk("ovf_sticky", overflow_o, 1);
        chk("ovf_drained_ready", evt_ready_o, 1);

        // Asynchronous reset mid-stream, between clock edges.
        evt_valid_i = 1'b1;
        evt_data_i = 8'($urandom);
        step();
        #2 rst_ni = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        #1 rst_ni = 1'b1;

        // Wrap: random writes with a reader three cycles behind.
        hist = '{0, 0, 0};
        for (int cyc = 0; cyc < 300 && m_wr < 20; cyc++) begin
            int nrd;
            evt_valid_i = ($urandom_range(0, 3) != 0);
            evt_data_i = 8'($urandom);
            nrd = hist.pop_front();
            while (rd_cnt < nrd) begin
                chk("rd_data", buf_data_o[(rd_cnt % D)*DW +: DW], exp_q.pop_front());
                rd_cnt++;
            end
            step();
            hist.push_back(m_wr);
        end
        chk("wrap_count", (m_wr >= 20) ? 1 : 0, 1);
        chk("wrap_seen", seen_wrap, 1);
        evt_valid_i = 1'b0;
        while (rd_cnt < m_wr) begin
            chk("rd_tail", buf_data_o[(rd_cnt % D)*DW +: DW], exp_q.pop_front());
            rd_cnt++;
        end
        repeat (3) step();
        chk("final_level", level_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
